// File: rtl/tdm_pkg.sv
// Shared definitions for the two-slot TDM mux/demux channel.
package tdm_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned ERR_W_DEF = 8;

  // Frame-alignment states; 2'd3 is unused and recovers to ST_HUNT.
  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SLOT1 = 2'd1,
    ST_SLOT0 = 2'd2
  } state_t;

endpackage

// File: rtl/dmx2.sv
// Combinational 1:2 steering: s=0 targets slot 0, s=1 targets slot 1.
module dmx2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             en,
  output logic             we0,
  output logic             we1,
  output logic [WIDTH-1:0] q_c
);

  // Decode the slot select into per-slot write enables.
  always_comb begin
    we0 = en & ~s;
    we1 = en & s;
    q_c = d;
  end

endmodule

// File: rtl/tdm_dmx2.sv
// Two-slot TDM demultiplexer with frame alignment and framing-error count.
module tdm_dmx2
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             out_valid,
  output logic             locked,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt
);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   h0_q;
  logic [WIDTH-1:0]   h0_d;
  logic [WIDTH-1:0]   y0_d;
  logic [WIDTH-1:0]   y1_d;
  logic               out_valid_d;
  logic               frame_err_d;
  logic [ERR_W-1:0]   err_cnt_d;

  logic               steer_s;
  logic               steer_en;
  logic               we0;
  logic               we1;
  logic [WIDTH-1:0]   dq;

  // A sync word always reloads h0; a non-sync word in SLOT1 completes the pair.
  always_comb begin
    steer_s  = ~sync & (state_q == ST_SLOT1);
    steer_en = in_valid & (sync | (state_q == ST_SLOT1));
  end

  dmx2 #(.WIDTH(WIDTH)) u_steer (
    .d   (d),
    .s   (steer_s),
    .en  (steer_en),
    .we0 (we0),
    .we1 (we1),
    .q_c (dq)
  );

  // Next-state, datapath loads and error detection.
  always_comb begin
    state_d     = state_q;
    h0_d        = h0_q;
    y0_d        = y0;
    y1_d        = y1;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (we0) begin
      h0_d = dq;
    end
    if (we1) begin
      y0_d        = h0_q;
      y1_d        = dq;
      out_valid_d = 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        if (in_valid && sync) state_d = ST_SLOT1;
      end
      ST_SLOT1: begin
        if (in_valid) begin
          if (sync) frame_err_d = 1'b1;
          else      state_d     = ST_SLOT0;
        end
      end
      ST_SLOT0: begin
        if (in_valid) begin
          if (sync) begin
            state_d = ST_SLOT1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    err_cnt_d = err_cnt;
    if (frame_err_d && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt + ERR_W'(1);
    end
  end

  // State and output registers; reset overrides any input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      h0_q      <= '0;
      y0        <= '0;
      y1        <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      h0_q      <= h0_d;
      y0        <= y0_d;
      y1        <= y1_d;
      out_valid <= out_valid_d;
      frame_err <= frame_err_d;
      locked    <= (state_d != ST_HUNT);
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_tdm_dmx2.sv
// Scoreboard bench for tdm_dmx2: directed words with hand-computed responses.
module tb_tdm_dmx2;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  d = '0;
  logic          in_valid = 1'b0;
  logic          sync = 1'b0;
  logic [W-1:0]  y0;
  logic [W-1:0]  y1;
  logic          out_valid;
  logic          locked;
  logic          frame_err;
  logic [EW-1:0] err_cnt;

  tdm_dmx2 #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .in_valid  (in_valid),
    .sync      (sync),
    .y0        (y0),
    .y1        (y1),
    .out_valid (out_valid),
    .locked    (locked),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic          ov;
    logic          fe;
    logic          lk;
    logic [W-1:0]  ey0;
    logic [W-1:0]  ey1;
    logic [EW-1:0] cnt;
    string         tag;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s cyc=%0d got=%0h want=%0h", tag, name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every output against the record due at this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s/missed due=%0d cyc=%0d", e.tag, e.due, cyc);
      end else begin
        chk("out_valid", e.tag, 32'(out_valid), 32'(e.ov));
        chk("frame_err", e.tag, 32'(frame_err), 32'(e.fe));
        chk("locked",    e.tag, 32'(locked),    32'(e.lk));
        chk("y0",        e.tag, 32'(y0),        32'(e.ey0));
        chk("y1",        e.tag, 32'(y1),        32'(e.ey1));
        chk("err_cnt",   e.tag, 32'(err_cnt),   32'(e.cnt));
      end
    end
  end

  task automatic push(input string tag, input logic ov, input logic fe, input logic lk,
                      input logic [W-1:0] ey0, input logic [W-1:0] ey1,
                      input logic [EW-1:0] cnt);
    exp_t e;
    e.due = cyc + 1; e.ov = ov; e.fe = fe; e.lk = lk;
    e.ey0 = ey0; e.ey1 = ey1; e.cnt = cnt; e.tag = tag;
    q.push_back(e);
    last = e;
  endtask

  // Reset cycle with a live slot-1 word on the bus: reset must win.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; d = 8'hAA; sync = 1'b0;
    push(tag, 0, 0, 0, 8'h00, 8'h00, 2'd0);
  endtask

  task automatic word(input string tag, input logic [W-1:0] dv, input logic sv,
                      input logic ov, input logic fe, input logic lk,
                      input logic [W-1:0] ey0, input logic [W-1:0] ey1,
                      input logic [EW-1:0] cnt);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; d = dv; sync = sv;
    push(tag, ov, fe, lk, ey0, ey1, cnt);
  endtask

  // Idle cycles with garbage on d/sync: nothing may change.
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; d = W'($urandom); sync = 1'($urandom);
      push(tag, 0, 0, last.lk, last.ey0, last.ey1, last.cnt);
    end
  endtask

  initial begin
    do_reset("rst0");

    word("clean", 8'hA5, 1, 0, 0, 1, 8'h00, 8'h00, 2'd0);
    word("clean", 8'h3C, 0, 1, 0, 1, 8'hA5, 8'h3C, 2'd0);
    word("clean", 8'h0F, 1, 0, 0, 1, 8'hA5, 8'h3C, 2'd0);
    word("clean", 8'hF0, 0, 1, 0, 1, 8'h0F, 8'hF0, 2'd0);

    do_reset("rst1");
    word("gap", 8'hA5, 1, 0, 0, 1, 8'h00, 8'h00, 2'd0);
    idle("gap", 3);
    word("gap", 8'h3C, 0, 1, 0, 1, 8'hA5, 8'h3C, 2'd0);
    idle("gap", 3);
    word("gap", 8'h0F, 1, 0, 0, 1, 8'hA5, 8'h3C, 2'd0);
    idle("gap", 3);
    word("gap", 8'hF0, 0, 1, 0, 1, 8'h0F, 8'hF0, 2'd0);
    idle("gap", 2);

    do_reset("rst2");
    word("presync", 8'h11, 1, 0, 0, 1, 8'h00, 8'h00, 2'd0);
    word("presync", 8'h22, 1, 0, 1, 1, 8'h00, 8'h00, 2'd1);
    word("presync", 8'h33, 0, 1, 0, 1, 8'h22, 8'h33, 2'd1);

    do_reset("rst3");
    word("miss", 8'h01, 1, 0, 0, 1, 8'h00, 8'h00, 2'd0);
    word("miss", 8'h02, 0, 1, 0, 1, 8'h01, 8'h02, 2'd0);
    word("miss", 8'h44, 0, 0, 1, 0, 8'h01, 8'h02, 2'd1);
    word("miss", 8'h55, 0, 0, 0, 0, 8'h01, 8'h02, 2'd1);
    word("miss", 8'h66, 1, 0, 0, 1, 8'h01, 8'h02, 2'd1);
    word("miss", 8'h77, 0, 1, 0, 1, 8'h66, 8'h77, 2'd1);

    do_reset("rst4");
    word("sat", 8'h10, 1, 0, 0, 1, 8'h00, 8'h00, 2'd0);
    word("sat", 8'h11, 1, 0, 1, 1, 8'h00, 8'h00, 2'd1);
    word("sat", 8'h12, 1, 0, 1, 1, 8'h00, 8'h00, 2'd2);
    word("sat", 8'h13, 1, 0, 1, 1, 8'h00, 8'h00, 2'd3);
    word("sat", 8'h14, 1, 0, 1, 1, 8'h00, 8'h00, 2'd3);
    word("sat", 8'h15, 1, 0, 1, 1, 8'h00, 8'h00, 2'd3);

    do_reset("rst5");
    word("midrst", 8'h99, 1, 0, 0, 1, 8'h00, 8'h00, 2'd0);
    do_reset("midrst");
    word("midrst", 8'hAA, 0, 0, 0, 0, 8'h00, 8'h00, 2'd0);
    idle("tail", 2);

    repeat (3) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s/unchecked due=%0d", e.tag, e.due);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
